hdmi_burst_sched: RTL and testbench
===================================

HDMI_BURST_SCHED -- requirements
Module: hdmi_burst_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width.
REQ-002 SHALL have parameter BURST_BYTES, default 32, the bytes moved per engine burst (8 beats x 4 B).
REQ-003 SHALL have parameter LINE_W, default 12, the width of the line counter.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, the watchdog limit (used only under HDMI_SCHED_TIMEOUT_EN).
REQ-005 SHALL have ports:
- ACLK  in  1  clock; single clock domain.
- ARESET  in  1  reset; synchronous, active-high.
- cfg_enable  in  1  scheduler enable.
- cfg_base_addr  in  ADDR_W  frame base byte address.
- cfg_stride  in  ADDR_W  byte offset between line starts.
- cfg_bursts_per_line  in  8  bursts per line.
- cfg_lines  in  LINE_W  lines per frame.
- vsync_start  in  1  one-cycle frame start pulse.
- line_req  in  1  level; the line buffer has room for one line.
- txn_init  out  1  one-cycle burst start pulse to the burst engine INIT_AXI_TXN.
- txn_addr  out  ADDR_W  burst start address.
- txn_done  in  1  burst complete pulse (engine TXN_DONE).
- txn_error  in  1  engine ERROR, sampled with txn_done.
- line_done  out  1  one-cycle pulse after the last burst of a line.
- frame_done  out  1  one-cycle pulse after the last line.
- busy  out  1  high in every state except IDLE.
- cur_line  out  LINE_W  index of the line being fetched.
- err_sticky  out  1  latched error.
- err_clr  in  1  clears err_sticky and leaves HALT.

Function
REQ-006 SHALL implement the FSM states IDLE, WAIT_LINE, ISSUE, WAIT_DONE and HALT.
REQ-007 IDLE: on vsync_start & cfg_enable & cfg_lines!=0 & cfg_bursts_per_line!=0 SHALL latch all cfg_* inputs, clear the line and burst counters, set line_addr=cfg_base_addr, and go to WAIT_LINE; otherwise vsync_start is ignored.
REQ-008 WAIT_LINE: line_req high SHALL move the FSM to ISSUE on the next edge.
REQ-009 ISSUE SHALL last exactly 1 cycle, assert txn_init=1 with txn_addr=line_addr+burst_idx*BURST_BYTES, then go to WAIT_DONE.
REQ-010 txn_addr SHALL be held stable from ISSUE until txn_done is accepted; txn_init SHALL never be asserted on two consecutive cycles.
REQ-011 WAIT_DONE, txn_done & txn_error: SHALL set err_sticky and go to HALT.
REQ-012 WAIT_DONE, txn_done & !txn_error, burst_idx < bursts-1: SHALL increment burst_idx and go to ISSUE.
REQ-013 WAIT_DONE, last burst of a line: SHALL pulse line_done, clear burst_idx, increment cur_line and add the stride to line_addr.
- Next state: WAIT_LINE, or, if this was the last line, pulse frame_done in the same cycle and go to IDLE.
REQ-014 Address arithmetic SHALL be modulo 2^ADDR_W; an overflow wraps silently.
REQ-015 vsync_start while busy SHALL be ignored; the frame in progress is unaffected.
REQ-016 cfg_enable falling mid-frame SHALL let an outstanding burst complete, then return to IDLE without pulsing frame_done; from WAIT_LINE it SHALL go to IDLE on the next edge.
REQ-017 Changes to cfg_* while busy SHALL have no effect until the next frame start.
REQ-018 HALT SHALL issue no txn_init and SHALL go to IDLE on err_clr, clearing err_sticky the same edge.
REQ-019 txn_done outside WAIT_DONE SHALL be ignored.

Reset
REQ-020 ARESET high at an ACLK edge SHALL force:
- state=IDLE;
- txn_init, line_done, frame_done, busy and err_sticky = 0;
- cur_line=0, burst_idx=0, txn_addr=0.
REQ-021 Reset mid-burst SHALL abandon the burst; a txn_done that arrives after reset is ignored per REQ-019.

Configuration
REQ-022 With HDMI_SCHED_TIMEOUT_EN defined:
- A counter SHALL run in WAIT_DONE.
- When it reaches TIMEOUT_CYCLES without txn_done, err_sticky SHALL be set and the FSM SHALL go to HALT.
REQ-023 Without HDMI_SCHED_TIMEOUT_EN, the FSM SHALL wait in WAIT_DONE indefinitely and no counter logic SHALL be present.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Base 0x1000_0000, stride 0x100, 2 bursts/line, 3 lines, line_req high, engine done 5 cycles after each init -> txn_addr sequence 0x10000000, 0x10000020, 0x10000100, 0x10000120, 0x10000200, 0x10000220; three line_done pulses, one frame_done pulse.
- line_req low for 50 cycles after line 0 -> no txn_init for 50 cycles; fetch resumes 2 cycles after line_req rises.
- txn_done with txn_error on burst 1 -> err_sticky=1, HALT, no further txn_init; err_clr -> IDLE, err_sticky=0.
- cfg_lines=0 with vsync_start -> busy stays 0.
- vsync_start during a frame -> ignored; cfg_enable dropped mid-burst -> outstanding done accepted, IDLE, no frame_done.
- HDMI_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, no txn_done -> HALT 16 cycles after the init.
- Base 0xFFFF_FFE0 -> second burst address 0x0000_0000.

Source files
------------

// File: rtl/hdmi_burst_sched.sv
// hdmi_burst_sched
// ----------------
// Frame fetch scheduler for an HDMI line buffer. At each frame start it walks
// the frame line by line. Each line is split into a fixed number of bursts, and
// the scheduler hands one start address at a time to an AXI burst engine. It
// waits for that engine to report completion before it issues the next burst.
//
// Ports
//   ACLK, ARESET         clock and synchronous active-high reset
//   cfg_enable           scheduler enable; dropping it ends the frame early
//   cfg_base_addr        frame base byte address
//   cfg_stride           byte offset between line starts
//   cfg_bursts_per_line  bursts per line
//   cfg_lines            lines per frame
//   vsync_start          one-cycle frame start pulse
//   line_req             level: the line buffer has room for one more line
//   txn_init / txn_addr  burst start pulse and burst start address to the engine
//   txn_done / txn_error burst completion pulse and error flag from the engine
//   line_done            one-cycle pulse after the last burst of a line
//   frame_done           one-cycle pulse after the last line of a frame
//   busy                 high whenever the FSM is outside IDLE
//   cur_line             index of the line being fetched
//   err_sticky           latched engine error (or watchdog expiry)
//   err_clr              clears err_sticky and releases HALT
//
// Optional feature
//   HDMI_SCHED_TIMEOUT_EN  when defined, a watchdog counts cycles spent in
//                          WAIT_DONE. If TIMEOUT_CYCLES pass without
//                          txn_done, the FSM sets err_sticky and enters HALT.

module hdmi_burst_sched #(
  parameter int ADDR_W         = 32,
  parameter int BURST_BYTES    = 32,
  parameter int LINE_W         = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_enable,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [7:0]        cfg_bursts_per_line,
  input  logic [LINE_W-1:0] cfg_lines,
  input  logic              vsync_start,
  input  logic              line_req,
  output logic              txn_init,
  output logic [ADDR_W-1:0] txn_addr,
  input  logic              txn_done,
  input  logic              txn_error,
  output logic              line_done,
  output logic              frame_done,
  output logic              busy,
  output logic [LINE_W-1:0] cur_line,
  output logic              err_sticky,
  input  logic              err_clr
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LINE,
    ISSUE,
    WAIT_DONE,
    HALT
  } state_e;

  state_e            state_q;

  // Frame configuration captured at frame start, so later cfg_* changes wait
  // until the next frame.
  logic [ADDR_W-1:0] stride_q;
  logic [7:0]        bursts_q;
  logic [LINE_W-1:0] lines_q;

  logic [ADDR_W-1:0] line_addr_q;
  logic [7:0]        burst_idx_q;
  logic [LINE_W-1:0] cur_line_q;

  logic              txn_init_q;
  logic [ADDR_W-1:0] txn_addr_q;
  logic              line_done_q;
  logic              frame_done_q;
  logic              busy_q;
  logic              err_q;

  // Combinational helpers for the FSM.
  logic              start_ok_d;
  logic              last_burst_d;
  logic              last_line_d;
  logic [ADDR_W-1:0] next_burst_addr_d;
  logic [ADDR_W-1:0] next_line_addr_d;

  assign start_ok_d   = vsync_start & cfg_enable
                      & (cfg_lines != '0) & (cfg_bursts_per_line != '0);
  assign last_burst_d = (burst_idx_q == (bursts_q - 8'd1));
  assign last_line_d  = (cur_line_q == (lines_q - LINE_W'(1)));

  // Address arithmetic is truncated to ADDR_W bits, so an overflow wraps to
  // the bottom of the address space.
  assign next_burst_addr_d = line_addr_q
                           + (ADDR_W'(burst_idx_q + 8'd1) * ADDR_W'(BURST_BYTES));
  assign next_line_addr_d  = line_addr_q + stride_q;

`ifdef HDMI_SCHED_TIMEOUT_EN
  localparam int TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;
`else
  // Without the watchdog this parameter only takes part in elaboration. This
  // empty block keeps it referenced without adding any logic.
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_param_unused
  end
`endif

  // Single FSM. Every output comes from a register. The pulse outputs default
  // low on each cycle, so each pulse lasts exactly one cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      stride_q     <= '0;
      bursts_q     <= '0;
      lines_q      <= '0;
      line_addr_q  <= '0;
      burst_idx_q  <= '0;
      cur_line_q   <= '0;
      txn_init_q   <= 1'b0;
      txn_addr_q   <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef HDMI_SCHED_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      txn_init_q   <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_ok_d) begin
            stride_q    <= cfg_stride;
            bursts_q    <= cfg_bursts_per_line;
            lines_q     <= cfg_lines;
            line_addr_q <= cfg_base_addr;
            burst_idx_q <= '0;
            cur_line_q  <= '0;
            busy_q      <= 1'b1;
            state_q     <= WAIT_LINE;
          end
        end

        WAIT_LINE: begin
          if (!cfg_enable) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (line_req) begin
            // The first burst of a line starts at the line address.
            txn_init_q <= 1'b1;
            txn_addr_q <= line_addr_q;
            state_q    <= ISSUE;
          end
        end

        ISSUE: begin
`ifdef HDMI_SCHED_TIMEOUT_EN
          tmo_q   <= TmoW'(1);
`endif
          state_q <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (txn_done) begin
            if (txn_error) begin
              err_q   <= 1'b1;
              state_q <= HALT;
            end else if (!cfg_enable) begin
              // The outstanding burst is complete. End the frame here, with
              // no frame_done.
              burst_idx_q <= '0;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end else if (!last_burst_d) begin
              // txn_init is re-raised at least one cycle after the last
              // ISSUE, so two init pulses can never sit back to back.
              burst_idx_q <= burst_idx_q + 8'd1;
              txn_init_q  <= 1'b1;
              txn_addr_q  <= next_burst_addr_d;
              state_q     <= ISSUE;
            end else begin
              line_done_q <= 1'b1;
              burst_idx_q <= '0;
              cur_line_q  <= cur_line_q + LINE_W'(1);
              line_addr_q <= next_line_addr_d;
              if (last_line_d) begin
                frame_done_q <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= IDLE;
              end else begin
                state_q <= WAIT_LINE;
              end
            end
`ifdef HDMI_SCHED_TIMEOUT_EN
          end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            // The counter reaches TIMEOUT_CYCLES on this edge with no done.
            err_q   <= 1'b1;
            state_q <= HALT;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
`endif
          end
        end

        HALT: begin
          if (err_clr) begin
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign txn_init   = txn_init_q;
  assign txn_addr   = txn_addr_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign cur_line   = cur_line_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_hdmi_burst_sched.sv
// tb_hdmi_burst_sched
// Directed bench for hdmi_burst_sched. The burst engine is played by hand:
// every init is answered with txn_done five cycles later. Expected addresses
// and pulses are written out as constants.

module tb_hdmi_burst_sched;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cfg_enable;
  logic [31:0] cfg_base_addr;
  logic [31:0] cfg_stride;
  logic [7:0]  cfg_bursts_per_line;
  logic [11:0] cfg_lines;
  logic        vsync_start;
  logic        line_req;
  logic        txn_init;
  logic [31:0] txn_addr;
  logic        txn_done;
  logic        txn_error;
  logic        line_done;
  logic        frame_done;
  logic        busy;
  logic [11:0] cur_line;
  logic        err_sticky;
  logic        err_clr;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  hdmi_burst_sched #(
    .ADDR_W(32), .BURST_BYTES(32), .LINE_W(12), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_enable(cfg_enable),
    .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride),
    .cfg_bursts_per_line(cfg_bursts_per_line), .cfg_lines(cfg_lines),
    .vsync_start(vsync_start), .line_req(line_req), .txn_init(txn_init),
    .txn_addr(txn_addr), .txn_done(txn_done), .txn_error(txn_error),
    .line_done(line_done), .frame_done(frame_done), .busy(busy),
    .cur_line(cur_line), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 ACLK = ~ACLK;

  // Advance one edge, then settle so outputs are read away from the edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Load a frame configuration and pulse vsync_start for one edge.
  task automatic applyStimulus(input logic [31:0] base, input logic [31:0] stride,
                               input logic [7:0] bpl, input logic [11:0] lines);
    cfg_base_addr       = base;
    cfg_stride          = stride;
    cfg_bursts_per_line = bpl;
    cfg_lines           = lines;
    vsync_start         = 1'b1;
    step();
    vsync_start         = 1'b0;
  endtask

  // Wait (bounded) for an init, check address, hold, single-cycle init,
  // then answer with done on the fifth edge after the init.
  task automatic doBurst(input string tag, input logic [31:0] expAddr,
                         input logic err, input logic expLd, input logic expFd);
    int n = 0;
    while (txn_init !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    checkOutput({tag, "_init"}, {31'd0, txn_init}, 32'd1);
    checkOutput({tag, "_addr"}, txn_addr, expAddr);
    step();
    checkOutput({tag, "_init_once"}, {31'd0, txn_init}, 32'd0);
    repeat (3) step();
    checkOutput({tag, "_hold"}, txn_addr, expAddr);
    txn_done  = 1'b1;
    txn_error = err;
    step();
    txn_done  = 1'b0;
    txn_error = 1'b0;
    checkOutput({tag, "_line_done"}, {31'd0, line_done}, {31'd0, expLd});
    checkOutput({tag, "_frame_done"}, {31'd0, frame_done}, {31'd0, expFd});
  endtask

  initial begin
    int inits;
    ARESET = 1'b1; cfg_enable = 1'b1; cfg_base_addr = '0; cfg_stride = '0;
    cfg_bursts_per_line = '0; cfg_lines = '0; vsync_start = 1'b0;
    line_req = 1'b1; txn_done = 1'b0; txn_error = 1'b0; err_clr = 1'b0;
    step(); step();
    ARESET = 1'b0;

    // Reset state
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_init", {31'd0, txn_init}, 32'd0);
    checkOutput("rst_addr", txn_addr, 32'd0);
    checkOutput("rst_line", {20'd0, cur_line}, 32'd0);
    checkOutput("rst_err", {31'd0, err_sticky}, 32'd0);
    checkOutput("rst_pulses", {30'd0, line_done, frame_done}, 32'd0);

    // Basic 3-line frame, two bursts per line
    $display("[TB] basic frame");
    applyStimulus(32'h1000_0000, 32'h100, 8'd2, 12'd3);
    checkOutput("f1_busy", {31'd0, busy}, 32'd1);
    doBurst("f1_b0", 32'h1000_0000, 1'b0, 1'b0, 1'b0);
    doBurst("f1_b1", 32'h1000_0020, 1'b0, 1'b1, 1'b0);
    checkOutput("f1_cur_line", {20'd0, cur_line}, 32'd1);
    doBurst("f1_b2", 32'h1000_0100, 1'b0, 1'b0, 1'b0);
    doBurst("f1_b3", 32'h1000_0120, 1'b0, 1'b1, 1'b0);
    doBurst("f1_b4", 32'h1000_0200, 1'b0, 1'b0, 1'b0);
    doBurst("f1_b5", 32'h1000_0220, 1'b0, 1'b1, 1'b1);
    checkOutput("f1_idle", {31'd0, busy}, 32'd0);
    checkOutput("f1_lines", {20'd0, cur_line}, 32'd3);

    // line_req held low for 50 cycles after line 0
    $display("[TB] line_req backpressure");
    applyStimulus(32'h2000_0000, 32'h40, 8'd1, 12'd2);
    step();
    line_req = 1'b0;
    doBurst("bp_l0", 32'h2000_0000, 1'b0, 1'b1, 1'b0);
    inits = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (txn_init === 1'b1) inits++;
    end
    checkOutput("bp_no_init", inits, 32'd0);
    checkOutput("bp_busy", {31'd0, busy}, 32'd1);
    line_req = 1'b1;
    inits = 0;
    for (int i = 0; i < 2 && txn_init !== 1'b1; i++) step();
    checkOutput("bp_resume", {31'd0, txn_init}, 32'd1);
    doBurst("bp_l1", 32'h2000_0040, 1'b0, 1'b1, 1'b1);

    // Engine error on burst 1
    $display("[TB] engine error");
    applyStimulus(32'h3000_0000, 32'h80, 8'd2, 12'd2);
    doBurst("er_b0", 32'h3000_0000, 1'b0, 1'b0, 1'b0);
    doBurst("er_b1", 32'h3000_0020, 1'b1, 1'b0, 1'b0);
    checkOutput("er_sticky", {31'd0, err_sticky}, 32'd1);
    checkOutput("er_halt_busy", {31'd0, busy}, 32'd1);
    inits = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (txn_init === 1'b1) inits++;
    end
    checkOutput("er_no_init", inits, 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("er_cleared", {31'd0, err_sticky}, 32'd0);
    checkOutput("er_idle", {31'd0, busy}, 32'd0);

    // Zero-sized frames are ignored
    $display("[TB] zero config");
    applyStimulus(32'h1234_0000, 32'h100, 8'd2, 12'd0);
    checkOutput("z_lines_busy", {31'd0, busy}, 32'd0);
    applyStimulus(32'h1234_0000, 32'h100, 8'd0, 12'd2);
    checkOutput("z_bursts_busy", {31'd0, busy}, 32'd0);

    // vsync while busy ignored, cfg change ignored, enable dropped mid-burst
    $display("[TB] vsync while busy and enable drop");
    applyStimulus(32'h4000_0000, 32'h100, 8'd2, 12'd2);
    doBurst("en_b0", 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    vsync_start = 1'b1;
    cfg_base_addr = 32'h5000_0000;
    cfg_bursts_per_line = 8'd1;
    step();
    vsync_start = 1'b0;
    checkOutput("en_addr_kept", txn_addr, 32'h4000_0020);
    checkOutput("en_busy", {31'd0, busy}, 32'd1);
    cfg_enable = 1'b0;
    step(); step();
    txn_done = 1'b1;
    step();
    txn_done = 1'b0;
    checkOutput("en_idle", {31'd0, busy}, 32'd0);
    checkOutput("en_no_frame_done", {31'd0, frame_done}, 32'd0);
    inits = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (txn_init === 1'b1) inits++;
    end
    checkOutput("en_no_init", inits, 32'd0);

    // Enable dropped while waiting for a line
    cfg_enable = 1'b1;
    line_req = 1'b0;
    applyStimulus(32'h4000_0000, 32'h100, 8'd1, 12'd1);
    checkOutput("wl_busy", {31'd0, busy}, 32'd1);
    cfg_enable = 1'b0;
    step();
    checkOutput("wl_idle", {31'd0, busy}, 32'd0);
    cfg_enable = 1'b1;
    line_req = 1'b1;

    // Reset mid-burst, late txn_done ignored
    $display("[TB] reset mid-burst");
    applyStimulus(32'h6000_0000, 32'h100, 8'd1, 12'd1);
    step();
    checkOutput("rb_init", {31'd0, txn_init}, 32'd1);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    checkOutput("rb_addr", txn_addr, 32'd0);
    txn_done = 1'b1;
    step();
    txn_done = 1'b0;
    checkOutput("rb_busy", {31'd0, busy}, 32'd0);
    checkOutput("rb_pulses", {30'd0, line_done, frame_done}, 32'd0);

    // Address wrap at top of address space
    $display("[TB] address wrap");
    applyStimulus(32'hFFFF_FFE0, 32'h40, 8'd2, 12'd1);
    doBurst("wr_b0", 32'hFFFF_FFE0, 1'b0, 1'b0, 1'b0);
    doBurst("wr_b1", 32'h0000_0000, 1'b0, 1'b1, 1'b1);

`ifdef HDMI_SCHED_TIMEOUT_EN
    // Watchdog: no done -> HALT 16 cycles after the init
    $display("[TB] watchdog");
    applyStimulus(32'h7000_0000, 32'h100, 8'd1, 12'd1);
    step();
    checkOutput("to_init", {31'd0, txn_init}, 32'd1);
    repeat (15) step();
    checkOutput("to_not_yet", {31'd0, err_sticky}, 32'd0);
    step();
    checkOutput("to_sticky", {31'd0, err_sticky}, 32'd1);
    checkOutput("to_halt_busy", {31'd0, busy}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("to_cleared", {31'd0, busy}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
